// File: rtl/poly_voice_mixer.sv
// ---------------------------------------------------------------------------
// poly_voice_mixer : N-voice serial sample mixer with attenuation/saturation
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module poly_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int TIMEOUT    = 64,
    parameter int ATTN_W     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           generate_next_sample,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    input  logic [ATTN_W-1:0]              master_attn,
    input  logic                           clear_flags,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           new_sample_ready,
    output logic                           underrun,
    output logic                           overrun,
    output logic                           busy
);

    localparam int ACC_W = SAMPLE_W + 4;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {5'b00000, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {5'b11111, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_ACCUM   = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [NUM_VOICES-1:0]                act_q, act_d;
    logic [NUM_VOICES-1:0]                got_q, got_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  smp_q, smp_d;
    logic [TMR_W-1:0]                     timer_q, timer_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic signed [ACC_W-1:0]              acc_q, acc_d;
    logic [SAMPLE_W-1:0]                  sample_q, sample_d;
    logic                                 rdy_q, rdy_d;
    logic                                 under_q, under_d;
    logic                                 over_q, over_d;

    logic [NUM_VOICES-1:0]                w_cap;
    logic signed [ACC_W-1:0]              w_term;
    logic signed [ACC_W-1:0]              w_sum;
    logic signed [ACC_W-1:0]              w_shift;
    logic                                 w_under_set;
    logic                                 w_over_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            act_q    <= '0;
            got_q    <= '0;
            smp_q    <= '0;
            timer_q  <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            rdy_q    <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            got_q    <= got_d;
            smp_q    <= smp_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            sample_q <= sample_d;
            rdy_q    <= rdy_d;
            under_q  <= under_d;
            over_q   <= over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        got_d       = got_q;
        smp_d       = smp_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        rdy_d       = 1'b0;
        w_cap       = '0;
        w_under_set = 1'b0;
        w_over_set  = generate_next_sample && (state_q != S_IDLE);

        w_term  = (act_q[idx_q] && got_q[idx_q])
                ? {{4{smp_q[idx_q][SAMPLE_W-1]}}, smp_q[idx_q]} : '0;
        w_sum   = acc_q + w_term;
        // The final add, shift and clamp share one cycle so the result lands on OUTPUT entry.
        w_shift = w_sum >>> master_attn;

        case (state_q)
            S_IDLE: begin
                if (generate_next_sample) begin
                    act_d   = voice_active;
                    w_cap   = voice_ready & voice_active;
                    got_d   = w_cap;
                    timer_d = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_cap   = voice_ready & act_q;
                got_d   = got_q | w_cap;
                timer_d = timer_q + 1'b1;
                if (&(got_d | ~act_q)) begin
                    state_d = S_ACCUM;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    w_under_set = 1'b1;
                    state_d     = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = w_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    if (w_shift > SAT_MAX) begin
                        sample_d = SAT_MAX[SAMPLE_W-1:0];
                    end else if (w_shift < SAT_MIN) begin
                        sample_d = SAT_MIN[SAMPLE_W-1:0];
                    end else begin
                        sample_d = w_shift[SAMPLE_W-1:0];
                    end
                    rdy_d   = 1'b1;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_cap[i]) begin
                smp_d[i] = voice_sample[i*SAMPLE_W +: SAMPLE_W];
            end
        end

        under_d = (under_q && !clear_flags) || w_under_set;
        over_d  = (over_q && !clear_flags) || w_over_set;
    end

    assign sample_out       = sample_q;
    assign new_sample_ready = rdy_q;
    assign underrun         = under_q;
    assign overrun          = over_q;
    assign busy             = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_poly_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_poly_voice_mixer : scoreboard bench for poly_voice_mixer (4 voices)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_poly_voice_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        generate_next_sample;
    logic [3:0]  voice_active;
    logic [63:0] voice_sample;
    logic [3:0]  voice_ready;
    logic [2:0]  master_attn;
    logic        clear_flags;
    logic [15:0] sample_out;
    logic        new_sample_ready;
    logic        underrun;
    logic        overrun;
    logic        busy;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    int          lat_q[$];
    logic [15:0] mon_e;
    int          mon_l;

    poly_voice_mixer #(
        .NUM_VOICES(4), .SAMPLE_W(16), .TIMEOUT(64), .ATTN_W(3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .generate_next_sample(generate_next_sample),
        .voice_active        (voice_active),
        .voice_sample        (voice_sample),
        .voice_ready         (voice_ready),
        .master_attn         (master_attn),
        .clear_flags         (clear_flags),
        .sample_out          (sample_out),
        .new_sample_ready    (new_sample_ready),
        .underrun            (underrun),
        .overrun             (overrun),
        .busy                (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] m, input logic [63:0] s,
                                          input logic [2:0] a);
        int sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) sum += int'($signed(s[i*16 +: 16]));
        end
        sum = sum >>> a;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return 16'(sum);
    endfunction

    always @(negedge clk) begin
        if (new_sample_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_l = lat_q.pop_front();
                chk("sample_out", {16'd0, sample_out}, {16'd0, mon_e});
                chk("latency_cycle", cyc, mon_l);
            end
        end
    end

    // mode 0: plain mix; 1: extra request during ACCUM; 2: reset during ACCUM
    task automatic run_mix(input logic [3:0] act, input logic [3:0] pm, input logic [63:0] s,
                           input logic [2:0] a, input logic exp_under, input int mode);
        int req_c;
        int done_c;
        @(negedge clk);
        generate_next_sample = 1'b1;
        voice_active         = act;
        voice_sample         = s;
        master_attn          = a;
        req_c                = cyc;
        done_c               = req_c + 1;
        for (int i = 0; i < 4; i++) begin
            if (pm[i]) begin
                @(negedge clk);
                generate_next_sample = 1'b0;
                voice_ready          = 4'(1 << i);
                if (act[i]) done_c = cyc;
            end
        end
        @(negedge clk);
        generate_next_sample = 1'b0;
        voice_ready          = 4'b0;
        if (((pm | ~act) & 4'hF) != 4'hF) done_c = req_c + 64;
        if (mode == 2) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_sample_out", {16'd0, sample_out}, 32'd0);
            chk("rst_ready", {31'd0, new_sample_ready}, 32'd0);
            chk("rst_underrun", {31'd0, underrun}, 32'd0);
            chk("rst_overrun", {31'd0, overrun}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            repeat (10) @(negedge clk);
            return;
        end
        exp_q.push_back(model(act & pm, s, a));
        lat_q.push_back(done_c + 5);
        if (mode == 1) begin
            @(negedge clk);
            generate_next_sample = 1'b1;
            @(negedge clk);
            generate_next_sample = 1'b0;
        end
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("ready_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
            lat_q.delete();
        end
        repeat (4) @(negedge clk);
        chk("underrun", {31'd0, underrun}, {31'd0, exp_under});
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset                = 1'b1;
        generate_next_sample = 1'b0;
        voice_active         = 4'b0;
        voice_sample         = 64'b0;
        voice_ready          = 4'b0;
        master_attn          = 3'd0;
        clear_flags          = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_sample_out", {16'd0, sample_out}, 32'd0);
        chk("reset_ready", {31'd0, new_sample_ready}, 32'd0);
        chk("reset_underrun", {31'd0, underrun}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        run_mix(4'hF, 4'hF, {16'd7, 16'hFFCE, 16'd200, 16'd100}, 3'd0, 1'b0, 0);
        run_mix(4'hF, 4'hF, {4{16'h7000}}, 3'd0, 1'b0, 0);
        run_mix(4'hF, 4'hF, {4{16'h9000}}, 3'd0, 1'b0, 0);
        run_mix(4'hF, 4'hF, {4{16'd1000}}, 3'd2, 1'b0, 0);
        run_mix(4'b0001, 4'b0001, {48'd0, 16'hFFFD}, 3'd1, 1'b0, 0);
        run_mix(4'b0101, 4'hF, {16'd100, 16'd2, 16'd100, 16'd1}, 3'd0, 1'b0, 0);

        run_mix(4'hF, 4'b1011, {16'd30, 16'd999, 16'd20, 16'd10}, 3'd0, 1'b1, 0);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("underrun_cleared", {31'd0, underrun}, 32'd0);

        run_mix(4'hF, 4'hF, {16'd4, 16'd3, 16'd2, 16'd1}, 3'd0, 1'b0, 1);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        run_mix(4'b0000, 4'b0000, {4{16'h1234}}, 3'd0, 1'b0, 0);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        run_mix(4'hF, 4'hF, {4{16'h0123}}, 3'd0, 1'b0, 2);
        run_mix(4'hF, 4'hF, {16'd8, 16'd7, 16'hFFFA, 16'd5}, 3'd0, 1'b0, 0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
